if_fetch_unit: RTL and testbench

- Parametrised instruction-fetch stage: PC register, PC+step increment, branch redirect mux and IF/ID pipeline register, in one block.
- Talks to a variable-latency instruction memory over a req/gnt/rvalid handshake, with one request outstanding at a time.
- Adds ID-stage stall, redirect flush with in-flight response discard, and a 1-entry skid buffer.
- Sits between instruction memory and the decode stage.

---
 rtl/if_pkg.sv | 19 +
 rtl/if_skid_buf.sv | 48 ++++
 rtl/if_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_t : fetch FSM states (request, wait, drop, hold)
//   DEF_RESET_PC  : default PC after reset
//   DEF_PC_STEP   : default sequential PC increment in bytes
//   NOP_INSTR     : instruction value presented by an empty IF/ID register
package if_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  localparam int unsigned DEF_RESET_PC = 0;
  localparam int unsigned DEF_PC_STEP  = 4;
  localparam int unsigned NOP_INSTR    = 0;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {instr, npc} skid buffer between fetch and the IF/ID register.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   clear              : drop the held entry (redirect); wins over load/unload
//   load               : capture load_instr/load_npc, buffer becomes full
//   unload             : release the held entry, buffer becomes empty
//   load_instr/load_npc: entry being captured
//   full               : an entry is held
//   instr/npc          : held entry
module if_skid_buf
  import if_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              unload,
  input  logic [DATA_W-1:0] load_instr,
  input  logic [ADDR_W-1:0] load_npc,
  output logic              full,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] npc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

  // Payload is only meaningful while full, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      instr <= load_instr;
      npc   <= load_npc;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, PC+step, redirect mux and IF/ID
// register, talking to a variable-latency instruction memory with a single
// outstanding req/gnt/rvalid transaction.
// Ports:
//   clk, rst             : clock, asynchronous active-low reset
//   ex_mem_pc_src/_npc   : redirect request and target (same-cycle effect)
//   id_stall             : decode cannot accept, IF/ID holds
//   imem_req/imem_addr   : fetch request and address
//   imem_gnt             : request accepted
//   imem_rvalid/_rdata   : response
//   id_valid/id_instr/id_npc : IF/ID register contents
// Optional feature (macro IF_FETCH_PERF_CNT_EN): adds saturating counters
//   perf_fetch_cnt (responses delivered) and perf_redirect_cnt (redirect cycles).
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int unsigned PC_STEP  = DEF_PC_STEP,
  parameter int unsigned RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_mem_pc_src,
  input  logic [ADDR_W-1:0] ex_mem_npc,
  input  logic              id_stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_npc
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_redirect_cnt
`endif
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_p0;
  logic [ADDR_W-1:0] fetch_npc_p0;
  logic              accept_gnt, resp, can_accept;
  logic              skid_load, skid_unload, skid_full;
  logic [DATA_W-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_npc;

  // A redirect kills any grant or response arriving in the same cycle.
  assign accept_gnt  = (state_q == ST_REQ) && imem_gnt && !ex_mem_pc_src;
  assign resp        = (state_q == ST_WAIT) && imem_rvalid && !ex_mem_pc_src;
  assign can_accept  = !id_valid || !id_stall;
  assign skid_load   = resp && !can_accept;
  assign skid_unload = skid_full && !id_stall && !ex_mem_pc_src;

  // Redirect target is visible on the bus in the very cycle it is requested.
  assign imem_addr = ex_mem_pc_src ? ex_mem_npc : pc_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_REQ;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_REQ:  if (accept_gnt) state_d = ST_WAIT;
      ST_WAIT: begin
        if (ex_mem_pc_src) state_d = imem_rvalid ? ST_REQ : ST_DROP;
        else if (resp)     state_d = skid_load ? ST_HOLD : ST_REQ;
      end
      // A response landing with a fresh redirect closes the dropped
      // transaction, so there is nothing left to wait for.
      ST_DROP: begin
        if (imem_rvalid)        state_d = ST_REQ;
        else if (ex_mem_pc_src) state_d = ST_DROP;
      end
      ST_HOLD: if (ex_mem_pc_src || skid_unload) state_d = ST_REQ;
      default: state_d = ST_REQ;
    endcase
  end

  // Request is masked during reset even though the state already reads REQ.
  always_comb begin
    imem_req = rst && (state_q == ST_REQ);
  end

  // ---- fetch stage (p0): PC and captured next-PC of the outstanding fetch ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_p0 <= ADDR_W'(RESET_PC);
    end else if (ex_mem_pc_src) begin
      pc_p0 <= ex_mem_npc;
    end else if (accept_gnt) begin
      pc_p0 <= pc_p0 + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (accept_gnt) fetch_npc_p0 <= pc_p0 + ADDR_W'(PC_STEP);
  end

  if_skid_buf #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (ex_mem_pc_src),
    .load      (skid_load),
    .unload    (skid_unload),
    .load_instr(imem_rdata),
    .load_npc  (fetch_npc_p0),
    .full      (skid_full),
    .instr     (skid_instr),
    .npc       (skid_npc)
  );

  // ---- IF/ID register (p1): skid drains ahead of any new response ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid <= 1'b0;
      id_instr <= DATA_W'(NOP_INSTR);
      id_npc   <= '0;
    end else if (ex_mem_pc_src) begin
      id_valid <= 1'b0;
    end else if (skid_unload) begin
      id_valid <= 1'b1;
      id_instr <= skid_instr;
      id_npc   <= skid_npc;
    end else if (resp && can_accept) begin
      id_valid <= 1'b1;
      id_instr <= imem_rdata;
      id_npc   <= fetch_npc_p0;
    end else if (!id_stall) begin
      id_valid <= 1'b0;
    end
  end

`ifdef IF_FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt    <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (resp)          perf_fetch_cnt    <= sat_inc(perf_fetch_cnt);
      if (ex_mem_pc_src) perf_redirect_cnt <= sat_inc(perf_redirect_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_pc_src;
  logic [31:0] ex_mem_npc;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_npc;

  int checks = 0;
  int errors = 0;

  // memory responder controls
  int mem_lat = 1;
  bit gnt_en  = 1'b1;
  bit pending = 1'b0;
  int cnt     = 0;
  logic [31:0] addr_q = '0;

  if_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .ex_mem_pc_src(ex_mem_pc_src),
    .ex_mem_npc   (ex_mem_npc),
    .id_stall     (id_stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_npc       (id_npc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory: decides gnt/rvalid on the falling edge for the next rising edge.
  // A grant during a redirect is shown but not tracked, since the fetch
  // unit must ignore it.
  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (pending) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = instr_of(addr_q);
          pending     = 1'b0;
        end
      end
      imem_gnt = gnt_en && imem_req;
      if (imem_gnt && !ex_mem_pc_src) begin
        pending = 1'b1;
        cnt     = mem_lat;
        addr_q  = imem_addr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic v, input logic [31:0] npc);
    chk({tag, "_valid"}, {31'd0, id_valid}, {31'd0, v});
    if (v) begin
      chk({tag, "_npc"}, id_npc, npc);
      chk({tag, "_instr"}, id_instr, instr_of(npc - 32'd4));
    end
  endtask

  initial begin
    rst           = 1'b0;
    ex_mem_pc_src = 1'b0;
    ex_mem_npc    = '0;
    id_stall      = 1'b0;

    // ---- reset state ----
    tick(); tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_npc", id_npc, 32'd0);

    // ---- 1-cycle memory, sequential fetch (C0..C6) ----
    rst = 1'b1;
    #1;
    chk("c0_req", {31'd0, imem_req}, 32'd1);
    chk("c0_addr", imem_addr, 32'h0);
    tick();
    chk("c1_req", {31'd0, imem_req}, 32'd0);
    chk_if("c1", 1'b0, 0);
    tick();
    chk_if("c2", 1'b1, 32'h4);
    chk("c2_addr", imem_addr, 32'h4);
    tick();
    chk_if("c3", 1'b0, 0);
    tick();
    chk_if("c4", 1'b1, 32'h8);
    chk("c4_addr", imem_addr, 32'h8);
    tick();
    chk_if("c5", 1'b0, 0);
    tick();
    chk_if("c6", 1'b1, 32'hC);
    chk("c6_addr", imem_addr, 32'hC);

    // ---- 3-cycle latency: single outstanding request ----
    mem_lat = 3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lat3_req", {31'd0, imem_req}, 32'd0);
      chk_if("lat3", 1'b0, 0);
    end
    tick();
    chk_if("lat3_c10", 1'b1, 32'h10);
    chk("lat3_addr", imem_addr, 32'h10);
    mem_lat = 1;
    tick();
    chk_if("c11", 1'b0, 0);
    tick();
    chk_if("c12", 1'b1, 32'h14);

    // ---- stall 6 cycles: IF/ID held, skid fills, requests stop ----
    id_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_if("stall", 1'b1, 32'h14);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    id_stall = 1'b0;
    tick();
    chk_if("unstall_skid", 1'b1, 32'h18);
    chk("unstall_addr", imem_addr, 32'h18);
    chk("unstall_req", {31'd0, imem_req}, 32'd1);
    tick();
    chk_if("c20", 1'b0, 0);
    tick();
    chk_if("c21", 1'b1, 32'h1C);

    // ---- redirect during WAIT: in-flight response discarded ----
    mem_lat = 3;
    tick();
    ex_mem_pc_src = 1'b1;
    ex_mem_npc    = 32'h100;
    tick();
    ex_mem_pc_src = 1'b0;
    chk("drop_req", {31'd0, imem_req}, 32'd0);
    chk_if("drop_c23", 1'b0, 0);
    tick();
    chk_if("drop_c24", 1'b0, 0);
    tick();
    chk_if("drop_c25", 1'b0, 0);
    chk("redir_req", {31'd0, imem_req}, 32'd1);
    chk("redir_addr", imem_addr, 32'h100);
    mem_lat = 1;
    tick();
    chk_if("c26", 1'b0, 0);
    tick();
    chk_if("redir_first", 1'b1, 32'h104);

    // ---- redirect with stall and full skid ----
    id_stall = 1'b1;
    tick();
    tick();
    chk_if("hold_c29", 1'b1, 32'h104);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    ex_mem_pc_src = 1'b1;
    ex_mem_npc    = 32'h200;
    tick();
    ex_mem_pc_src = 1'b0;
    chk_if("hold_redir", 1'b0, 0);
    chk("hold_redir_req", {31'd0, imem_req}, 32'd1);
    chk("hold_redir_addr", imem_addr, 32'h200);
    id_stall = 1'b0;
    tick();
    chk_if("skid_cleared", 1'b0, 0);
    tick();
    chk_if("hold_resume", 1'b1, 32'h204);

    // ---- async reset mid-WAIT, late response ignored ----
    mem_lat = 3;
    tick();
    chk("rw_req", {31'd0, imem_req}, 32'd0);
    gnt_en = 1'b0;
    rst    = 1'b0;
    #1;
    chk_if("async_rst", 1'b0, 0);
    chk("async_rst_instr", id_instr, 32'd0);
    chk("async_rst_npc", id_npc, 32'd0);
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0);
    tick();
    chk_if("late_rv_c35", 1'b0, 0);
    tick();
    chk_if("late_rv_c36", 1'b0, 0);
    chk("late_rv_addr", imem_addr, 32'h0);
    gnt_en  = 1'b1;
    mem_lat = 1;
    tick();
    chk_if("c37", 1'b0, 0);
    tick();
    chk_if("restart", 1'b1, 32'h4);

    // ---- redirect in REQ: comb address, same-cycle gnt ignored, PC wrap ----
    ex_mem_pc_src = 1'b1;
    ex_mem_npc    = 32'hFFFF_FFFC;
    #1;
    chk("reqredir_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    ex_mem_pc_src = 1'b0;
    chk("reqredir_req", {31'd0, imem_req}, 32'd1);
    chk("reqredir_addr2", imem_addr, 32'hFFFF_FFFC);
    chk_if("reqredir_c39", 1'b0, 0);
    tick();
    chk_if("c40", 1'b0, 0);
    tick();
    chk("wrap_npc", id_npc, 32'h0);
    chk("wrap_instr", id_instr, instr_of(32'hFFFF_FFFC));
    chk("wrap_valid", {31'd0, id_valid}, 32'd1);
    chk("wrap_addr", imem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
